uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
8N1 UART receiver. It is the receive-side counterpart of the team's uart_tx and uses the same CLK_FREQ/BAUD_RATE parameterisation. The block synchronises the asynchronous serial line and samples each bit at mid-period. It delivers each received byte as a one-cycle valid pulse to downstream logic such as a command parser or FIFO, and it flags framing errors.

Parameters:
CLK_FREQ, 25_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (217 at defaults), must be >= 4; HALF_BIT = CLKS_PER_BIT/2 (108)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_reset_n  input  1  asynchronous, active-low reset
i_rx  input  1  asynchronous serial line, idle high
o_data  output  8  last correctly framed byte, LSB received first
o_valid  output  1  one-cycle pulse when o_data is updated
o_frame_err  output  1  one-cycle pulse when the stop bit samples low
o_busy  output  1  high while in S_START, S_DATA or S_STOP

Behaviour:
- Interface: one clock (i_clk). Reset i_reset_n is asynchronous, active-low.
- Reset (immediate, asynchronous): state S_HUNT; sync flops 0; baud counter 0; bit index 0; shift register 0; o_data 0x00; o_valid 0; o_frame_err 0.
- Input path: i_rx passes through a 2-flop synchroniser; rx_s is the second flop. No logic uses raw i_rx.
- Baud counter width is $clog2(CLKS_PER_BIT). The counter resets to 0 on every state change.
- S_HUNT: wait for rx_s==1, then go to S_IDLE. This prevents a line that is low at reset release from being taken as a start bit.
- S_IDLE: when rx_s==0, go to S_START.
- S_START: count up. At count==HALF_BIT-1, re-check rx_s.
  - rx_s==0: go to S_DATA, bit index 0.
  - rx_s==1: glitch. Return to S_IDLE with no output pulse.
- S_DATA: at count==CLKS_PER_BIT-1, shift rx_s into shift[7] (right shift, LSB-first).
  - Bit index 7: go to S_STOP.
  - Otherwise: increment bit index.
- S_STOP: at count==CLKS_PER_BIT-1:
  - rx_s==1: o_data<=shift, o_valid=1 for one cycle, go to S_IDLE.
  - rx_s==0: o_frame_err=1 for one cycle, o_data unchanged, no o_valid, go to S_HUNT (break handling).
- o_valid and o_frame_err are registered, never high together, and are 0 in every cycle other than their pulse.
- Latency: o_valid rises 2 + 1 + HALF_BIT + 9*CLKS_PER_BIT clocks (±2) after the first clock edge that registers i_rx low. At defaults this is 2064±2.
- Back-to-back frames: re-arming in S_IDLE happens 1 clock after the stop sample. A start bit that immediately follows a stop bit is accepted.
- o_data holds its value until the next good frame. There is no downstream backpressure; a consumer must take data on the o_valid pulse.
- Reset mid-frame: partial byte is discarded, no pulses. After release the block hunts for idle-high before accepting a start bit.
- Baud tolerance: correct reception for a transmitter bit period within ±3% of CLKS_PER_BIT.

Test Plan:
- Loopback from uart_tx (default params) sending 0xA5 -> exactly one o_valid, o_data=0xA5, o_frame_err never high, o_busy low after frame.
- Consecutive frames 0x00, 0xFF, 0x55 (no idle gap) -> three o_valid pulses with those values in order, no frame errors.
- 50-clock low glitch on idle line -> no o_valid or o_frame_err; o_busy high then low within HALF_BIT+4 clocks of the glitch start.
- Frame 0x3C with stop bit held low for 2 bit periods -> one o_frame_err pulse, no o_valid, o_data keeps prior value. Then line high 1 bit, send 0x81 -> o_valid, o_data=0x81.
- Assert i_reset_n low during data bit 3 of 0xF0 -> o_busy/o_valid/o_data go 0 without a clock edge. Release with line low, then line high, then send 0x12 -> single o_valid with 0x12 only.
- Direct stimulus at 210 and 224 clocks/bit sending 0x6B -> o_data=0x6B each time, no frame error.

Source files
------------

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// 8N1 UART receiver: 2-flop synchronised line, mid-bit sampling; o_valid lands 2+HALF_BIT+9*CLKS_PER_BIT clocks after the start edge.
// No backpressure: o_data/o_valid is a one-cycle offer the consumer must take; o_frame_err pulses on a low stop bit.
module uart_rx #(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_HUNT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic             rx_m;
    logic             rx_s;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             sample_bit;
    logic             capture;
    logic             frame_bad;
    logic             cnt_clr;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_m <= 1'b0;
            rx_s <= 1'b0;
        end else begin
            rx_m <= i_rx;
            rx_s <= rx_m;
        end
    end

    always_comb begin
        state_nxt  = state;
        sample_bit = 1'b0;
        capture    = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            // A line held low through reset release must not look like a start bit.
            S_HUNT: begin
                if (rx_s) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (cnt == HALF_LAST) state_nxt = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    sample_bit = 1'b1;
                    if (bit_idx == 3'd7) state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    if (rx_s) begin
                        capture   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = S_HUNT;
                    end
                end
            end
            default: state_nxt = S_HUNT;
        endcase
    end

    assign o_busy  = (state == S_START) || (state == S_DATA) || (state == S_STOP);
    // Counter restarts on every state change and after each data sample so it always times one bit.
    assign cnt_clr = (state_nxt != state) || sample_bit || !o_busy;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= S_HUNT;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            state <= state_nxt;
            if (cnt_clr) cnt <= '0;
            else         cnt <= cnt + 1'b1;
            if (state == S_START && state_nxt == S_DATA)
                bit_idx <= 3'd0;
            else if (sample_bit && bit_idx != 3'd7)
                bit_idx <= bit_idx + 3'd1;
            if (sample_bit) shift <= {rx_s, shift[7:1]};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data      <= 8'h00;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= capture;
            o_frame_err <= frame_bad;
            if (capture) o_data <= shift;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Bench for uart_rx: bit-banged 8N1 source, queue scoreboard of expected bytes and frame errors.
module tb_uart_rx;

    localparam int CPB  = 217;
    localparam int HALF = 108;

    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         exp_err     = 0;
    int         cyc         = 0;
    int         valid_cyc   = -1;
    logic [7:0] last_good   = 8'h00;

    always #5 i_clk = ~i_clk;

    uart_rx dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy)
    );

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // Output monitor: every pulse is matched against what the stimulus queued.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge i_clk);
            if (o_valid && o_frame_err) begin
                vectors++;
                miscompares++;
                $display("FAIL pulse_overlap: o_valid and o_frame_err both high at cycle %0d", cyc);
            end
            if (o_valid) begin
                valid_cyc = cyc;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_valid: o_data=%02h, no byte expected", o_data);
                end else begin
                    e = exp_q.pop_front();
                    if (o_data !== e) begin
                        miscompares++;
                        $display("FAIL rx_data: got %02h, expected %02h", o_data, e);
                    end
                end
            end
            if (o_frame_err) begin
                vectors++;
                if (exp_err == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_frame_err: pulse at cycle %0d, none expected", cyc);
                end else begin
                    exp_err--;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_lvl, input int stop_len);
        i_rx = 1'b0;
        repeat (cpb) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (cpb) @(negedge i_clk);
        end
        i_rx = stop_lvl;
        repeat (cpb * stop_len) @(negedge i_clk);
        i_rx = 1'b1;
    endtask

    task automatic test_reset;
        i_reset_n = 1'b0;
        i_rx      = 1'b1;
        repeat (3) @(negedge i_clk);
        vectors++; if (o_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %02h, expected 00", o_data); end
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, expected 0", o_valid); end
        vectors++; if (o_frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b, expected 0", o_frame_err); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", o_busy); end
        i_reset_n = 1'b1;
        repeat (20) @(negedge i_clk);
    endtask

    task automatic test_loopback;
        int start_cyc;
        int lat;
        exp_q.push_back(8'hA5);
        valid_cyc = -1;
        start_cyc = cyc + 1;
        send_byte(8'hA5, CPB, 1'b1, 1);
        repeat (CPB) @(negedge i_clk);
        lat = valid_cyc - start_cyc;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL loopback_count: %0d bytes still pending, expected 0", exp_q.size()); end
        vectors++; if (lat < 2062 || lat > 2066) begin miscompares++; $display("FAIL loopback_latency: got %0d clocks, expected 2064+-2", lat); end
        vectors++; if (o_data !== 8'hA5) begin miscompares++; $display("FAIL loopback_hold: o_data=%02h, expected a5", o_data); end
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL loopback_busy: got %b, expected 0", o_busy); end
        last_good = 8'hA5;
    endtask

    task automatic test_back_to_back;
        logic [7:0] pat [3];
        pat = '{8'h00, 8'hFF, 8'h55};
        for (int i = 0; i < 3; i++) exp_q.push_back(pat[i]);
        for (int i = 0; i < 3; i++) send_byte(pat[i], CPB, 1'b1, 1);
        repeat (CPB) @(negedge i_clk);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL b2b_count: %0d bytes still pending, expected 0", exp_q.size()); end
        vectors++; if (o_data !== 8'h55) begin miscompares++; $display("FAIL b2b_last: o_data=%02h, expected 55", o_data); end
        last_good = 8'h55;
    endtask

    task automatic test_glitch;
        int  fall  = -1;
        bit  saw_hi = 1'b0;
        i_rx = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clk);
            if (i == 49) i_rx = 1'b1;
            if (o_busy) saw_hi = 1'b1;
            if (saw_hi && !o_busy && fall < 0) fall = i;
        end
        vectors++; if (saw_hi !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_rise: o_busy never high, expected high"); end
        vectors++; if (fall < 0 || fall > HALF + 4) begin miscompares++; $display("FAIL glitch_busy_fall: fell at %0d clocks, expected <= %0d", fall, HALF + 4); end
        vectors++; if (o_data !== last_good) begin miscompares++; $display("FAIL glitch_data: o_data=%02h, expected %02h", o_data, last_good); end
    endtask

    task automatic test_frame_err;
        exp_err = 1;
        send_byte(8'h3C, CPB, 1'b0, 2);
        repeat (CPB) @(negedge i_clk);
        vectors++; if (exp_err != 0) begin miscompares++; $display("FAIL frame_err_count: %0d pulses missing, expected 0", exp_err); end
        vectors++; if (o_data !== last_good) begin miscompares++; $display("FAIL frame_err_hold: o_data=%02h, expected %02h", o_data, last_good); end
        exp_q.push_back(8'h81);
        send_byte(8'h81, CPB, 1'b1, 1);
        repeat (CPB) @(negedge i_clk);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL recover_count: %0d bytes pending, expected 0", exp_q.size()); end
        vectors++; if (o_data !== 8'h81) begin miscompares++; $display("FAIL recover_data: o_data=%02h, expected 81", o_data); end
        last_good = 8'h81;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        b = 8'hF0;
        i_rx = 1'b0;
        repeat (CPB) @(negedge i_clk);
        for (int i = 0; i < 3; i++) begin
            i_rx = b[i];
            repeat (CPB) @(negedge i_clk);
        end
        i_rx = b[3];
        repeat (CPB / 2) @(negedge i_clk);
        vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL pre_reset_busy: got %b, expected 1", o_busy); end
        #2 i_reset_n = 1'b0;
        #1;
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL async_busy: got %b, expected 0", o_busy); end
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL async_valid: got %b, expected 0", o_valid); end
        vectors++; if (o_data !== 8'h00) begin miscompares++; $display("FAIL async_data: got %02h, expected 00", o_data); end
        i_rx = 1'b0;
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (2 * CPB) @(negedge i_clk);
        vectors++; if (o_busy !== 1'b0) begin miscompares++; $display("FAIL hunt_busy: got %b with line low after reset, expected 0", o_busy); end
        i_rx = 1'b1;
        repeat (CPB) @(negedge i_clk);
        exp_q.push_back(8'h12);
        send_byte(8'h12, CPB, 1'b1, 1);
        repeat (CPB) @(negedge i_clk);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL post_reset_count: %0d bytes pending, expected 0", exp_q.size()); end
        vectors++; if (o_data !== 8'h12) begin miscompares++; $display("FAIL post_reset_data: o_data=%02h, expected 12", o_data); end
        last_good = 8'h12;
    endtask

    task automatic test_tolerance;
        int rates [2];
        rates = '{210, 224};
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(8'h6B);
            send_byte(8'h6B, rates[r], 1'b1, 1);
            repeat (CPB) @(negedge i_clk);
            vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL tol_count_%0d: %0d bytes pending, expected 0", rates[r], exp_q.size()); end
            vectors++; if (o_data !== 8'h6B) begin miscompares++; $display("FAIL tol_data_%0d: o_data=%02h, expected 6b", rates[r], o_data); end
        end
        last_good = 8'h6B;
    endtask

    initial begin
        i_reset_n = 1'b1;
        i_rx      = 1'b1;
        @(negedge i_clk);
        test_reset;
        test_loopback;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_mid_frame;
        test_tolerance;
        repeat (10) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
